// File: rtl/taylor_engine_arbiter.sv
// Round-robin arbiter sharing one Taylor-series cosine engine between N requesters.
// Holds the granted angle on the engine, sequences start/ready, and returns a tagged result.
module taylor_engine_arbiter #(
  parameter int W       = 24,
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_valid_i,
  input  logic [N*W-1:0]   req_angle_i,
  output logic [N-1:0]     req_ready_o,
  output logic             resp_valid_o,
  output logic [IDW-1:0]   resp_id_o,
  output logic [W-1:0]     resp_data_o,
  output logic             resp_error_o,
  output logic             busy_o,
  output logic             eng_start_o,
  output logic [W-1:0]     eng_angle_o,
  input  logic             eng_ready_i,
  input  logic [W-1:0]     eng_result_i,
  output logic [2:0]       state_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_CLR  = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESPOND   = 3'd4,
    S_RELEASE   = 3'd5
  } state_e;

  state_e         state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] id_q;
  logic [W-1:0]   eng_angle_q;
  logic           eng_start_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic           timeout_hit;
  logic           resp_valid_q;
  logic [IDW-1:0] resp_id_q;
  logic [W-1:0]   resp_data_q;
  logic           resp_error_q;

  logic           gnt_found;
  logic [IDW-1:0] gnt_id;
  logic [NW-1:0]  idx;
  logic [W-1:0]   gnt_angle;

  // Search starts one past the last winner, so the last winner comes last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = NW'((int'(rr_ptr_q) + k) % N);
      if (!gnt_found && req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = IDW'(idx);
      end
    end
  end

  assign gnt_angle   = req_angle_i[int'(gnt_id)*W +: W];
  assign req_ready_o = (rst_ni && state_q == S_IDLE && gnt_found)
                       ? ({{(N-1){1'b0}}, 1'b1} << gnt_id) : '0;

  assign cnt_d       = cnt_q + 1'b1;
  assign timeout_hit = (cnt_d >= CW'(TIMEOUT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= IDW'(N - 1);
      id_q         <= '0;
      eng_angle_q  <= '0;
      eng_start_q  <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
    end else begin
      eng_start_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            eng_angle_q <= gnt_angle;
            id_q        <= gnt_id;
            rr_ptr_q    <= gnt_id;
            eng_start_q <= 1'b1;
            state_q     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_CLR;
        end
        // A done level left over from the previous job must drop before we trust ready.
        S_WAIT_CLR: begin
          cnt_q <= cnt_d;
          if (timeout_hit) begin
            resp_valid_q <= 1'b1;
            resp_id_q    <= id_q;
            resp_data_q  <= '0;
            resp_error_q <= 1'b1;
            state_q      <= S_RESPOND;
          end else if (!eng_ready_i) begin
            state_q <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          cnt_q <= cnt_d;
          if (eng_ready_i) begin
            resp_valid_q <= 1'b1;
            resp_id_q    <= id_q;
            resp_data_q  <= eng_result_i;
            resp_error_q <= 1'b0;
            state_q      <= S_RESPOND;
          end else if (timeout_hit) begin
            resp_valid_q <= 1'b1;
            resp_id_q    <= id_q;
            resp_data_q  <= '0;
            resp_error_q <= 1'b1;
            state_q      <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          eng_start_q <= 1'b1;
          state_q     <= S_RELEASE;
        end
        S_RELEASE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_id_o    = resp_id_q;
  assign resp_data_o  = resp_data_q;
  assign resp_error_o = resp_error_q;
  assign busy_o       = (state_q != S_IDLE);
  assign eng_start_o  = eng_start_q;
  assign eng_angle_o  = eng_angle_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_taylor_engine_arbiter.sv
// Bench for taylor_engine_arbiter: behavioural engine stub, grant/response scoreboard, directed jobs.
// Handshake: a request is held on req_valid until req_ready pulses for it in the same cycle.
module tb_taylor_engine_arbiter;

  localparam int W       = 24;
  localparam int N       = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 64;
  localparam int EW      = 1 + IDW + W;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WAIT_CLR  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_RELEASE   = 3'd5;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_angle;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic [IDW-1:0] resp_id;
  logic [W-1:0]   resp_data;
  logic           resp_error;
  logic           busy;
  logic           eng_start;
  logic [W-1:0]   eng_angle;
  logic           eng_ready;
  logic [W-1:0]   eng_result;
  logic [2:0]     state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int acc_count = 0;
  int last_acc  = 0;
  bit have_last = 1'b0;
  bit gap_chk   = 1'b0;
  bit eng_dead  = 1'b0;

  logic [IDW-1:0] gnt_q[$];
  logic [EW-1:0]  exp_q[$];
  int             acc_cyc_q[$];

  taylor_engine_arbiter #(.W(W), .N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_angle_i(req_angle), .req_ready_o(req_ready),
    .resp_valid_o(resp_valid), .resp_id_o(resp_id), .resp_data_o(resp_data),
    .resp_error_o(resp_error), .busy_o(busy),
    .eng_start_o(eng_start), .eng_angle_o(eng_angle),
    .eng_ready_i(eng_ready), .eng_result_i(eng_result),
    .state_o(state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- engine stub: load, ready drops next cycle, done after 6 ----------------
  logic [1:0]   e_st;
  int           e_ph;
  logic         e_rdy;
  logic [W-1:0] e_ang;

  function automatic logic [W-1:0] cos_fx(input logic [W-1:0] a);
    case (a)
      24'd0:    cos_fx = 24'd1024;
      24'd512:  cos_fx = 24'd898;
      24'd1024: cos_fx = 24'd553;
      default:  cos_fx = 24'hFFFFFF;
    endcase
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      e_st <= 2'd0; e_ph <= 0; e_rdy <= 1'b0; e_ang <= '0; eng_result <= '0;
    end else begin
      case (e_st)
        2'd0: if (eng_start) begin e_st <= 2'd1; e_ph <= 1; e_ang <= eng_angle; end
        2'd1: begin
          e_ph <= e_ph + 1;
          if (e_ph + 1 == 2) e_rdy <= 1'b0;
          if (e_ph + 1 == 6) begin e_rdy <= 1'b1; eng_result <= cos_fx(e_ang); e_st <= 2'd2; end
        end
        default: if (eng_start) e_st <= 2'd0;
      endcase
    end
  end
  assign eng_ready = eng_dead ? 1'b0 : e_rdy;

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- accept monitor ----------------
  always @(negedge clk) begin
    if (!rst_ni) begin
      acc_cyc_q.delete();
      have_last = 1'b0;
    end else if (req_ready != '0) begin
      int g;
      logic [IDW-1:0] e;
      g = 0;
      for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
      acc_count++;
      check("ready_onehot", $countones(req_ready), 1);
      if (gnt_q.size() == 0) check("unexpected_grant", g, 99);
      else begin
        e = gnt_q.pop_front();
        check("grant_id", g, e);
      end
      acc_cyc_q.push_back(cyc);
      if (gap_chk && have_last) check("rr_gap", cyc - last_acc, 10);
      last_acc  = cyc;
      have_last = gap_chk;
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge clk) begin
    if (rst_ni && resp_valid) begin
      logic [EW-1:0] e;
      int a;
      if (exp_q.size() == 0) check("unexpected_resp", resp_id, 99);
      else begin
        e = exp_q.pop_front();
        check("resp_id", resp_id, e[W+IDW-1:W]);
        check("resp_data", resp_data, e[W-1:0]);
        check("resp_error", resp_error, e[EW-1]);
        if (acc_cyc_q.size() == 0) check("resp_no_accept", 0, 1);
        else begin
          a = acc_cyc_q.pop_front();
          check("resp_latency", cyc - a, e[EW-1] ? TIMEOUT + 2 : 8);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input int id, input logic [W-1:0] ang);
    @(posedge clk); #1;
    req_angle[id*W +: W] = ang;
    req_valid[id] = 1'b1;
  endtask

  task automatic expect_job(input int id, input logic [W-1:0] data, input logic err);
    gnt_q.push_back(IDW'(id));
    if (data !== 'x) exp_q.push_back({err, IDW'(id), data});
  endtask

  task automatic wait_acc(input int target);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(posedge clk);
      if (acc_count >= target) done = 1'b1;
    end
    #1;
    if (!done) check("accept_timeout", acc_count, target);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0) done = 1'b1;
    end
    if (!done) check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    bit seen;
    rst_ni = 1'b0; req_valid = '0; req_angle = '0;
    repeat (2) @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_eng_angle", eng_angle, 0);
    check("rst_state", state, ST_IDLE);
    check("rst_req_ready", req_ready, 0);
    rst_ni = 1'b1;

    // single request, first job after reset
    base = acc_count;
    drive(2, 24'd0); expect_job(2, 24'd1024, 1'b0);
    wait_acc(base + 1); req_valid[2] = 1'b0;

    // value check
    drive(0, 24'd1024); expect_job(0, 24'd553, 1'b0);
    wait_acc(base + 2); req_valid[0] = 1'b0;

    // back-to-back on requester 1: stale done must be ignored
    drive(1, 24'd1024); expect_job(1, 24'd553, 1'b0);
    wait_acc(base + 3); req_valid[1] = 1'b0;
    drive(1, 24'd0); expect_job(1, 24'd1024, 1'b0);
    wait_acc(base + 4); req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk); check("wait_clr_c1", state, ST_WAIT_CLR);
    @(negedge clk); check("wait_clr_c2", state, ST_WAIT_CLR);
    @(negedge clk); check("wait_done_after_clr", state, ST_WAIT_DONE);
    drain();

    // timeout with a dead engine
    eng_dead = 1'b1;
    base = acc_count;
    drive(3, 24'd512); expect_job(3, 24'd0, 1'b1);
    wait_acc(base + 1); req_valid[3] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("timeout_resp_seen", seen, 1);
    @(negedge clk);
    check("release_start", eng_start, 1);
    check("release_state", state, ST_RELEASE);
    @(negedge clk);
    check("post_release_busy", busy, 0);
    check("post_release_start", eng_start, 0);
    eng_dead = 1'b0;

    // round-robin, all held from reset
    @(negedge clk);
    rst_ni = 1'b0;
    req_angle = {24'd0, 24'd512, 24'd1024, 24'd0};
    req_valid = '1;
    gap_chk = 1'b1;
    base = acc_count;
    expect_job(0, 24'd1024, 1'b0);
    expect_job(1, 24'd553, 1'b0);
    expect_job(2, 24'd898, 1'b0);
    expect_job(3, 24'd1024, 1'b0);
    expect_job(0, 24'd1024, 1'b0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    wait_acc(base + 5);
    req_valid = '0;
    gap_chk = 1'b0;
    drain();

    // async reset mid WAIT_DONE aborts with no response
    base = acc_count;
    drive(2, 24'd512); gnt_q.push_back(IDW'(2));
    wait_acc(base + 1); req_valid[2] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (state == ST_WAIT_DONE) seen = 1'b1;
    end
    check("reach_wait_done", seen, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_resp_valid", resp_valid, 0);
    check("arst_resp_id", resp_id, 0);
    check("arst_resp_data", resp_data, 0);
    check("arst_resp_error", resp_error, 0);
    check("arst_busy", busy, 0);
    check("arst_eng_start", eng_start, 0);
    check("arst_eng_angle", eng_angle, 0);
    check("arst_state", state, ST_IDLE);
    req_angle = '0;
    req_angle[0*W +: W] = 24'd1024;
    req_angle[3*W +: W] = 24'd0;
    req_valid = 4'b1001;
    base = acc_count;
    expect_job(0, 24'd553, 1'b0);
    expect_job(3, 24'd1024, 1'b0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    wait_acc(base + 1); req_valid[0] = 1'b0;
    wait_acc(base + 2); req_valid[3] = 1'b0;
    drain();

    check("gnt_q_empty", gnt_q.size(), 0);
    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
